// File: rtl/ih_column_sequencer.sv
// Input-to-hidden weight memory sequencer: walks hidden columns, drives the MAC,
// and slots backprop column writes in at column boundaries only.
module ih_column_sequencer #(
    parameter int NUM_HIDDEN = 20,
    parameter int COL_W      = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             upd_req,
    input  logic [COL_W-1:0] upd_col,
    output logic             upd_ack,
    output logic             mem_read,
    output logic             mem_write,
    output logic [COL_W-1:0] mem_column,
    input  logic             mem_finish,
    output logic             mac_start,
    input  logic             mac_done,
    output logic [COL_W-1:0] node_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_MAC_GO   = 3'd2;
    localparam logic [2:0] S_MAC_WAIT = 3'd3;
    localparam logic [2:0] S_NEXT     = 3'd4;
    localparam logic [2:0] S_WR       = 3'd5;

    logic [2:0]       state, state_nxt;
    logic [COL_W-1:0] idx_nxt;
    logic [TW-1:0]    tmo_cnt;
    logic             ret_next;
    logic             start_pend;
    logic             accept_start;
    logic             tmo_evt;
    logic             tmo_hit;
    logic             last_col;
    logic             counting;

    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
    assign last_col = (node_idx == COL_W'(NUM_HIDDEN - 1));
    assign counting = (state == S_RD) || (state == S_WR) || (state == S_MAC_WAIT);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = node_idx;
        accept_start = 1'b0;
        tmo_evt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (upd_req) begin
                    state_nxt = S_WR;
                end else if (start || start_pend) begin
                    accept_start = 1'b1;
                    idx_nxt      = '0;
                    state_nxt    = S_RD;
                end
            end
            S_RD: begin
                if (mem_finish) begin
                    state_nxt = S_MAC_GO;
                end else if (tmo_hit) begin
                    tmo_evt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_MAC_GO: state_nxt = S_MAC_WAIT;
            S_MAC_WAIT: begin
                if (mac_done) begin
                    state_nxt = S_NEXT;
                end else if (tmo_hit) begin
                    tmo_evt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_NEXT: begin
                // Column boundary: the only point where a write may slip into a pass.
                if (upd_req) begin
                    state_nxt = S_WR;
                end else if (last_col) begin
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt   = node_idx + 1'b1;
                    state_nxt = S_RD;
                end
            end
            S_WR: begin
                if (mem_finish) begin
                    state_nxt = ret_next ? S_NEXT : S_IDLE;
                end else if (tmo_hit) begin
                    tmo_evt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            node_idx   <= '0;
            tmo_cnt    <= '0;
            ret_next   <= 1'b0;
            start_pend <= 1'b0;
            err        <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_column <= '0;
            mac_start  <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            state    <= state_nxt;
            node_idx <= idx_nxt;

            if (state_nxt != state) begin
                tmo_cnt <= '0;
            end else if (counting) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // Remember which state to resume once the write completes.
            if (state_nxt == S_WR && state != S_WR) begin
                ret_next <= (state == S_NEXT);
            end

            if (accept_start) begin
                start_pend <= 1'b0;
            end else if (start && (state != S_IDLE || upd_req)) begin
                start_pend <= 1'b1;
            end

            if (accept_start) begin
                err <= 1'b0;
            end else if (tmo_evt) begin
                err <= 1'b1;
            end

            mem_read  <= (state_nxt == S_RD);
            mem_write <= (state_nxt == S_WR);
            mac_start <= (state_nxt == S_MAC_GO);
            upd_ack   <= (state == S_WR) && mem_finish;

            if (state_nxt == S_RD) begin
                mem_column <= idx_nxt;
            end else if (state_nxt == S_WR) begin
                mem_column <= upd_col;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_NEXT) && !upd_req && last_col;

endmodule
